// File: rtl/rv32_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_lsu_pkg
//  Purpose  : Shared constants for the RV32I load/store unit: funct3 access
//             encodings, exception codes and the FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package rv32_lsu_pkg;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Exception codes reported alongside load_ready / store_done
    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

    // Transaction FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_lane_align
//  Purpose  : Combinational lane logic for the load/store unit. Builds store
//             strobes and replicated write data, extracts and extends load
//             data from the read word, and flags illegal/misaligned accesses.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_lane_align
    import rv32_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        is_load,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        illegal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and halfword lanes out of the read word
    always_comb begin
        w_byte = mem_rdata[7:0];
        case (addr_lo)
            2'b01:   w_byte = mem_rdata[15:8];
            2'b10:   w_byte = mem_rdata[23:16];
            2'b11:   w_byte = mem_rdata[31:24];
            default: w_byte = mem_rdata[7:0];
        endcase
        w_half = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    // Sign- or zero-extend the selected lane according to the access type
    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    load_data = {{16{w_half[15]}}, w_half};
            F3_W:    load_data = mem_rdata;
            F3_BU:   load_data = {24'd0, w_byte};
            F3_HU:   load_data = {16'd0, w_half};
            default: load_data = '0;
        endcase
    end

    // Legality: loads accept five encodings, stores only the signed three
    always_comb begin
        illegal = 1'b1;
        if (is_load) begin
            case (funct3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: illegal = 1'b0;
                default:                        illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_B, F3_H, F3_W: illegal = 1'b0;
                default:          illegal = 1'b1;
            endcase
        end
        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    end

    // Store byte enables and lane-replicated data; reads drive no strobes
    always_comb begin
        wstrb = 4'b0000;
        wdata = '0;
        if (!is_load) begin
            case (funct3)
                F3_B: begin
                    wstrb = 4'b0001 << addr_lo;
                    wdata = {4{store_data[7:0]}};
                end
                F3_H: begin
                    wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{store_data[15:0]}};
                end
                F3_W: begin
                    wstrb = 4'b1111;
                    wdata = store_data;
                end
                default: begin
                    wstrb = 4'b0000;
                    wdata = '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Load/store unit answering the control unit's load-stall
//             handshake. Runs one req/ack transaction on the data-memory bus
//             per accepted request and pulses load_ready / store_done.
//  Options  : LSU_TIMEOUT_EN - abort a bus request after MAX_WAIT cycles
//             without mem_ack and report exception code 11.
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit
    import rv32_lsu_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_load,
    input  logic        start_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        load_ready,
    output logic        store_done,
    output logic [31:0] load_data,
    output logic [1:0]  exc_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    generate
        if ((MAX_WAIT < 1) || (MAX_WAIT > 255)) begin : g_bad_max_wait
            $error("load_store_unit: MAX_WAIT must lie in 1..255");
        end
    endgenerate

    lsu_state_e  r_state;
    lsu_state_e  w_state_next;

    logic        r_is_load;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [1:0]  r_exc;
    logic [31:0] r_load_data;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;

    logic        w_idle;
    logic        w_start;
    logic [2:0]  w_al_funct3;
    logic [1:0]  w_al_addr_lo;
    logic        w_al_is_load;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_load_ext;
    logic        w_misaligned;
    logic        w_illegal;
    logic        w_timeout;

    // A load beats a simultaneous store; starts outside IDLE are dropped
    assign w_idle  = (r_state == ST_IDLE);
    assign w_start = w_idle && (start_load || start_store);

    // The lane aligner sees the live request in IDLE (strobes, legality)
    // and the captured request afterwards (read-data extraction).
    assign w_al_funct3  = w_idle ? funct3     : r_funct3;
    assign w_al_addr_lo = w_idle ? addr[1:0]  : r_addr_lo;
    assign w_al_is_load = w_idle ? start_load : r_is_load;

    lsu_lane_align u_lane_align (
        .funct3     (w_al_funct3),
        .addr_lo    (w_al_addr_lo),
        .is_load    (w_al_is_load),
        .store_data (store_data),
        .mem_rdata  (mem_rdata),
        .wstrb      (w_wstrb),
        .wdata      (w_wdata),
        .load_data  (w_load_ext),
        .misaligned (w_misaligned),
        .illegal    (w_illegal)
    );

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);
    logic [7:0] r_wait;

    // Count REQ cycles that pass without an acknowledge; idle outside REQ
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait <= '0;
        end else if (r_state != ST_REQ) begin
            r_wait <= '0;
        end else if (!mem_ack) begin
            r_wait <= r_wait + 8'd1;
        end
    end

    // Limit reached on this cycle; a coincident ack takes precedence
    assign w_timeout = (r_state == ST_REQ) && !mem_ack &&
                       ((r_wait + 8'd1) == c_max_wait);
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: faulty requests skip the bus and report directly
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_load || start_store) begin
                    w_state_next = (w_illegal || w_misaligned) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack || w_timeout) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Capture the request on acceptance and the result on completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_load   <= 1'b0;
            r_funct3    <= '0;
            r_addr_lo   <= '0;
            r_exc       <= EXC_NONE;
            r_load_data <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= 4'b0000;
        end else if (w_start) begin
            r_is_load   <= start_load;
            r_funct3    <= funct3;
            r_addr_lo   <= addr[1:0];
            r_mem_we    <= ~start_load;
            r_mem_addr  <= {addr[31:2], 2'b00};
            r_mem_wdata <= w_wdata;
            r_mem_wstrb <= w_wstrb;
            if (w_illegal) begin
                r_exc <= EXC_ILLEGAL;
            end else if (w_misaligned) begin
                r_exc <= EXC_MISALIGN;
            end else begin
                r_exc <= EXC_NONE;
            end
            if (start_load && (w_illegal || w_misaligned)) begin
                r_load_data <= '0;
            end
        end else if (r_state == ST_REQ) begin
            if (mem_ack) begin
                if (r_is_load) begin
                    r_load_data <= w_load_ext;
                end
            end else if (w_timeout) begin
                r_exc <= EXC_TIMEOUT;
                if (r_is_load) begin
                    r_load_data <= '0;
                end
            end
        end
    end

    // Handshake and bus outputs; mem_req decodes state so reset drops it at once
    assign mem_req    = (r_state == ST_REQ);
    assign busy       = (r_state == ST_REQ);
    assign load_ready = (r_state == ST_DONE) &&  r_is_load;
    assign store_done = (r_state == ST_DONE) && !r_is_load;
    assign exc_code   = (r_state == ST_DONE) ? r_exc : EXC_NONE;
    assign load_data  = r_load_data;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_wstrb  = r_mem_wstrb;

endmodule
`default_nettype wire
